// File: rtl/imm_extend_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_if
// Handshake bundle for the immediate-extension pipe.
//   Input side : InValid, InReady, InData[IN_WIDTH], InMode[2]
//   Output side: OutValid, OutReady, OutData[OUT_WIDTH]
// Modports:
//   slave  - the pipe itself (consumes the input stream, produces results)
//   master - the environment (produces immediates, consumes results)
// -----------------------------------------------------------------------------
interface imm_extend_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
);
    logic                 InValid;
    logic                 InReady;
    logic [IN_WIDTH-1:0]  InData;
    logic [1:0]           InMode;
    logic                 OutValid;
    logic                 OutReady;
    logic [OUT_WIDTH-1:0] OutData;

    modport slave (
        input  InValid, InData, InMode, OutReady,
        output InReady, OutValid, OutData
    );

    modport master (
        output InValid, InData, InMode, OutReady,
        input  InReady, OutValid, OutData
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Registered immediate-extension unit for the decode stage. Widens an IN_WIDTH
// immediate to OUT_WIDTH (zero / sign / upper / branch-offset) behind a
// valid/ready handshake with a 2-entry skid buffer (output register + skid).
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   bus        slave modport of imm_extend_pipe_if (In*/Out* handshake)
//   XferCount  out  16-bit saturating count of output transfers
//                   (present only when IMM_EXTEND_PIPE_STATS_EN is defined)
//
// Optional feature macro: IMM_EXTEND_PIPE_STATS_EN
// OUT_WIDTH must be >= IN_WIDTH+2.
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    imm_extend_pipe_if.slave     bus
`ifdef IMM_EXTEND_PIPE_STATS_EN
    ,
    output logic [15:0]          XferCount
`endif
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    // Extend one immediate according to its mode.
    function automatic logic [OUT_WIDTH-1:0] extend_imm(
        input logic [IN_WIDTH-1:0] data,
        input logic [1:0]          mode
    );
        logic [OUT_WIDTH-1:0] sext;
        logic [OUT_WIDTH-1:0] res;
        sext = {{PAD{data[IN_WIDTH-1]}}, data};
        case (mode)
            2'b00:   res = {{PAD{1'b0}}, data};
            2'b01:   res = sext;
            2'b10:   res = {data, {PAD{1'b0}}};
            2'b11:   res = {sext[OUT_WIDTH-3:0], 2'b00};  // top two sign bits fall off
            default: res = {OUT_WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [OUT_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic [OUT_WIDTH-1:0] ext_s;

    // Ready depends only on skid occupancy (and reset), never on OutReady.
    assign in_ready_s = ~skid_valid_q & ~Reset;
    assign in_fire_s  = bus.InValid & in_ready_s;
    assign out_fire_s = out_valid_q & bus.OutReady;
    assign ext_s      = extend_imm(bus.InData, bus.InMode);

    assign bus.InReady  = in_ready_s;
    assign bus.OutValid = out_valid_q;
    assign bus.OutData  = out_data_q;

    // Next-state for the output register and the skid entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // FULL: input is blocked; drain skid into the output on a transfer.
            if (out_fire_s) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = out_valid_q;
            end
        end else if (in_fire_s && out_valid_q && !bus.OutReady) begin
            // ONE, stalled: park the new item in the skid.
            skid_valid_d = 1'b1;
            skid_data_d  = ext_s;
        end else if (in_fire_s) begin
            // EMPTY, or ONE with a concurrent transfer: reload output, no bubble.
            out_valid_d = 1'b1;
            out_data_d  = ext_s;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;          // data intentionally held
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipe state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_WIDTH{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {OUT_WIDTH{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef IMM_EXTEND_PIPE_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    // Saturating output-transfer count.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (out_fire_s && (xfer_count_q != 16'hFFFF)) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end else begin
            xfer_count_d = xfer_count_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            xfer_count_q <= 16'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign XferCount = xfer_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
// Directed bench for imm_extend_pipe with a scoreboard queue: expected results
// are pushed when an input is accepted and compared as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic Clk = 1'b0;
    logic Reset;

    imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

`ifdef IMM_EXTEND_PIPE_STATS_EN
    logic [15:0] XferCount;
`endif

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
`ifdef IMM_EXTEND_PIPE_STATS_EN
        ,
        .XferCount (XferCount)
`endif
    );

    always #5 Clk = ~Clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] last_data;
    logic [15:0] xfer_model;
    int          n_out;

    function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
        logic signed [31:0] s;
        s = 32'(signed'(d));
        case (m)
            2'b00:   return {16'h0000, d};
            2'b01:   return s;
            2'b10:   return {d, 16'h0000};
            default: return s <<< 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge against the model, then advance.
    task automatic cycle();
        int   sz;
        logic acc;
        @(negedge Clk);
        sz = sb.size();
        chk("out_valid", {31'd0, bus.OutValid}, {31'd0, (sz != 0)});
        chk("in_ready",  {31'd0, bus.InReady},  {31'd0, (sz < 2)});
        if (sz != 0) chk("out_data", bus.OutData, sb[0]);
        else         chk("out_data_hold", bus.OutData, last_data);
`ifdef IMM_EXTEND_PIPE_STATS_EN
        chk("xfer_count", {16'd0, XferCount}, {16'd0, xfer_model});
`endif
        acc = bus.InValid && (sz < 2);
        if (sz != 0 && bus.OutReady) begin
            last_data = sb.pop_front();
            n_out++;
            if (xfer_model != 16'hFFFF) xfer_model++;
        end
        if (acc) sb.push_back(model_ext(bus.InData, bus.InMode));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        last_data    = 32'd0;
        xfer_model   = 16'd0;
        n_out        = 0;
        Reset        = 1'b1;
        bus.InValid  = 1'b0;
        bus.InData   = 16'h0000;
        bus.InMode   = 2'b00;
        bus.OutReady = 1'b0;

        // 1. reset state
        #2;
        chk("rst_in_ready",  {31'd0, bus.InReady},  32'd0);
        chk("rst_out_valid", {31'd0, bus.OutValid}, 32'd0);
        chk("rst_out_data",  bus.OutData,           32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        cycle();

        // 2. mode sweep, 1-cycle latency
        bus.OutReady = 1'b1;
        for (int m = 0; m < 4; m++) begin
            bus.InValid = 1'b1;
            bus.InData  = 16'h8001;
            bus.InMode  = 2'(m);
            cycle();
        end
        bus.InValid = 1'b0;
        cycle();
        cycle();

        // 3. backpressure into FULL, then drain in order
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1; bus.InData = 16'h0005; bus.InMode = 2'b01;
        cycle();
        bus.InData = 16'h7FFF; bus.InMode = 2'b00;
        cycle();
        bus.InValid = 1'b0;
        cycle();
        cycle();
        bus.OutReady = 1'b1;
        cycle();
        cycle();
        cycle();

        // 4. streaming 20 items back-to-back
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            bus.InValid = 1'b1;
            bus.InData  = 16'(16'hFFF6 + i);
            bus.InMode  = 2'b01;
            cycle();
        end
        bus.InValid = 1'b0;
        cycle();
        chk("stream_count", n_out, 32'd20);

        // 5. asynchronous reset while FULL
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1; bus.InData = 16'h1234; bus.InMode = 2'b10;
        cycle();
        bus.InData = 16'hABCD; bus.InMode = 2'b11;
        cycle();
        bus.InValid = 1'b0;
        cycle();
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, bus.OutValid}, 32'd0);
        chk("arst_in_ready",  {31'd0, bus.InReady},  32'd0);
        chk("arst_out_data",  bus.OutData,           32'd0);
        sb.delete();
        last_data  = 32'd0;
        xfer_model = 16'd0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        cycle();
        bus.InValid = 1'b1; bus.InData = 16'hC003; bus.InMode = 2'b11;
        cycle();
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        cycle();
        cycle();

`ifdef IMM_EXTEND_PIPE_STATS_EN
        // 6. counter saturation and no counting while stalled
        for (int i = 0; i < 70000; i++) begin
            bus.InValid = 1'b1;
            bus.InData  = 16'(i);
            bus.InMode  = 2'(i);
            cycle();
        end
        bus.OutReady = 1'b0;
        cycle();
        cycle();
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("xfer_sat", {16'd0, XferCount}, 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate-extension unit for the decode stage.
- Widens an IN_WIDTH immediate to OUT_WIDTH using one of four modes: zero, sign, upper (LUI) or branch-offset.
- Uses a valid/ready handshake and a 2-entry skid buffer, so decode can stall without losing an immediate.

Parameters:
- IN_WIDTH, 16, width of the incoming immediate field.
- OUT_WIDTH, 32, width of the extended result; must be >= IN_WIDTH+2.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  InData/InMode are valid this cycle.
- InReady  output  1  block can accept an item this cycle.
- InData  input  IN_WIDTH  raw immediate.
- InMode  input  2  00 zero-extend, 01 sign-extend, 10 upper, 11 branch offset.
- OutValid  output  1  OutData holds a valid result.
- OutReady  input  1  consumer accepts OutData this cycle.
- OutData  output  OUT_WIDTH  extended immediate.

Behaviour:
- Clocking and reset:
  - One clock (Clk).
  - Reset is asynchronous and active-high.
  - While Reset is high: OutValid=0, OutData=0, skid entry empty and cleared, InReady=0.
  - Reset asserted mid-operation discards both entries immediately.
- Transfers:
  - An input transfer occurs when InValid & InReady at a rising edge.
  - An output transfer occurs when OutValid & OutReady at a rising edge.
- Extension rules, with W=OUT_WIDTH and N=IN_WIDTH:
  - 00: {(W-N) zeros, InData}.
  - 01: {(W-N) copies of InData[N-1], InData}.
  - 10: {InData, (W-N) zeros}.
  - 11: (sign-extended value) << 2, truncated to W bits; the top two sign bits are dropped.
- Extension is combinational on the input side; the result is registered.
- Storage is an output register (OutData/OutValid) plus one skid register (SkidData/SkidValid).
- InReady = ~SkidValid & ~Reset. InReady is a function of registered state only; it never depends combinationally on OutReady.
- Latency: with the pipe empty, a result accepted at edge k has OutValid=1 after edge k, so it is visible in cycle k+1.
- Edge-by-edge state transitions (occupancy 0, 1 or 2):
  - EMPTY + in → ONE: output register loaded.
  - ONE + in, no out → FULL: new item goes to skid.
  - ONE + in + out → ONE: output register reloaded with the new item.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE: skid moves to the output register, SkidValid cleared. No input is possible because InReady=0.
  - FULL, no out → hold; OutData stable.
- Ordering: strict FIFO; results leave in acceptance order.
- OutData and OutValid must not change while OutValid=1 and OutReady=0.
- Simultaneous in and out in state ONE must give full throughput: one result per cycle with no bubble.
- When OutValid=0, OutData holds its last value. It is not cleared except by Reset.

Optional Feature:
- Macro: IMM_EXTEND_PIPE_STATS_EN.
- Defined:
  - Adds output port XferCount, 16 bits: the count of output transfers since reset.
  - Saturates at 16'hFFFF.
  - Reset value 0; increments on the same edge as an output transfer.
- Undefined:
  - No XferCount port and no counter logic.
  - All other behaviour is identical.

Test Plan:
1. Reset released, idle → OutValid=0, OutData=0, InReady=1 in the first cycle after Reset falls; InReady=0 while Reset=1.
2. Mode sweep, OutReady=1, InData=16'h8001 with modes 00/01/10/11 on consecutive cycles → OutData 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, on consecutive cycles, 1-cycle latency.
3. Backpressure, OutReady=0, send 16'h0005 (mode 01) then 16'h7FFF (mode 00) → InReady drops to 0 after the second accept. OutData stays 32'h00000005. On raising OutReady the outputs are 32'h00000005 then 32'h00007FFF, in order, with no loss.
4. Streaming, InValid=1 and OutReady=1 for 20 cycles with an incrementing immediate (mode 01) → 20 results, back-to-back, in order, InReady held at 1.
5. Reset asserted asynchronously mid-cycle while FULL → OutValid drops to 0 before the next edge. After release the pipe is empty and the next item takes 1-cycle latency.
6. With IMM_EXTEND_PIPE_STATS_EN defined, 70000 output transfers → XferCount=16'hFFFF and holds there. Stalled cycles do not increment the count.
